// File: rtl/door_input_cond.sv
// Door input conditioning: synchronizers, debouncers and one-shot key requests.
// Defining DOOR_INPUT_FAULT_EN adds a sticky end-switch plausibility fault that blocks key requests.
module door_input_cond #(
    parameter int DEB_CYCLES = 2000
) (
    input  logic clk2m,
    input  logic rst,
    input  logic key_up_raw,
    input  logic key_down_raw,
    input  logic sense_up_raw,
    input  logic sense_down_raw,
    output logic key_up,
    output logic key_down,
    output logic sense_up,
    output logic sense_down,
    output logic fault
);
    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // Channel order: 0 key_up, 1 key_down, 2 sense_up, 3 sense_down
    logic [3:0]    raw_s;
    logic [3:0]    sync1_r;
    logic [3:0]    sync2_r;
    logic [3:0]    deb_r;
    logic [3:0]    deb_prev_r;
    logic [3:0]    deb_next_s;
    logic [CW-1:0] cnt_r      [4];
    logic [CW-1:0] cnt_next_s [4];
    logic          key_up_r;
    logic          key_down_r;
    logic          key_up_next_s;
    logic          key_down_next_s;
    logic          fault_next_s;

    assign raw_s = {sense_down_raw, sense_up_raw, key_down_raw, key_up_raw};

    // Synchronizers, debounce state, edge history and key pulse registers
    always_ff @(posedge clk2m) begin
        if (rst) begin
            sync1_r    <= 4'b0000;
            sync2_r    <= 4'b0000;
            deb_r      <= 4'b0000;
            deb_prev_r <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                cnt_r[i] <= {CW{1'b0}};
            end
            key_up_r   <= 1'b0;
            key_down_r <= 1'b0;
        end else begin
            sync1_r    <= raw_s;
            sync2_r    <= sync1_r;
            deb_r      <= deb_next_s;
            deb_prev_r <= deb_r;
            for (int i = 0; i < 4; i++) begin
                cnt_r[i] <= cnt_next_s[i];
            end
            key_up_r   <= key_up_next_s;
            key_down_r <= key_down_next_s;
        end
    end

    // Debounce: a new level must persist DEB_CYCLES synchronized cycles; any return restarts the count
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            deb_next_s[i] = deb_r[i];
            cnt_next_s[i] = {CW{1'b0}};
            if (sync2_r[i] == deb_r[i]) begin
                cnt_next_s[i] = {CW{1'b0}};
            end else if (cnt_r[i] == CNT_LAST) begin
                deb_next_s[i] = sync2_r[i];
                cnt_next_s[i] = {CW{1'b0}};
            end else begin
                cnt_next_s[i] = cnt_r[i] + CNT_ONE;
            end
        end
    end

`ifdef DOOR_INPUT_FAULT_EN
    logic fault_r;

    assign fault_next_s = fault_r | (deb_r[2] & deb_r[3]);

    // Both end switches closed at once is implausible; latch until reset
    always_ff @(posedge clk2m) begin
        if (rst) begin
            fault_r <= 1'b0;
        end else begin
            fault_r <= fault_next_s;
        end
    end

    assign fault = fault_r;
`else
    assign fault_next_s = 1'b0;
    assign fault        = 1'b0;
`endif

    // Rising-edge pulses; the opposite key being held (or rising together) vetoes the request.
    // The next fault value is used so no pulse can appear in the first fault cycle.
    always_comb begin
        key_up_next_s   = deb_r[0] & ~deb_prev_r[0] & ~deb_r[1] & ~fault_next_s;
        key_down_next_s = deb_r[1] & ~deb_prev_r[1] & ~deb_r[0] & ~fault_next_s;
    end

    assign key_up     = key_up_r;
    assign key_down   = key_down_r;
    assign sense_up   = deb_r[2];
    assign sense_down = deb_r[3];

endmodule

// File: tb/tb_door_input_cond.sv
// Randomized and directed bench for door_input_cond against a sample-window reference model.
// Build with or without DOOR_INPUT_FAULT_EN; expectations follow the same macro.
module tb_door_input_cond;
    localparam int DEB = 4;

    logic clk2m = 1'b0;
    logic rst;
    logic key_up_raw, key_down_raw, sense_up_raw, sense_down_raw;
    logic key_up, key_down, sense_up, sense_down, fault;

    int n_vec = 0;
    int n_err = 0;
    int n_kup = 0;
    int n_kdn = 0;

    // Reference model: raw sample pipe, per-channel window of synchronized samples
    logic [3:0]     m_sh1, m_sh2, m_d, m_dprev;
    logic           m_kup, m_kdn, m_flt;
    logic [DEB-1:0] m_win  [4];
    int             m_fill [4];

    door_input_cond #(.DEB_CYCLES(DEB)) dut (
        .clk2m         (clk2m),
        .rst           (rst),
        .key_up_raw    (key_up_raw),
        .key_down_raw  (key_down_raw),
        .sense_up_raw  (sense_up_raw),
        .sense_down_raw(sense_down_raw),
        .key_up        (key_up),
        .key_down      (key_down),
        .sense_up      (sense_up),
        .sense_down    (sense_down),
        .fault         (fault)
    );

    always #250 clk2m = ~clk2m;

    task automatic check_eq(input string tag, input logic obs, input logic exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // A level is accepted once the last DEB synchronized samples all show it and it differs from d
    task automatic model_edge(input logic r, input logic [3:0] raw);
        logic [3:0] nd;
        logic       nf;
        if (r) begin
            m_sh1 = 4'b0; m_sh2 = 4'b0; m_d = 4'b0; m_dprev = 4'b0;
            m_kup = 1'b0; m_kdn = 1'b0; m_flt = 1'b0;
            for (int c = 0; c < 4; c++) begin
                m_win[c]  = '0;
                m_fill[c] = 0;
            end
        end else begin
            for (int c = 0; c < 4; c++) begin
                m_win[c] = {m_win[c][DEB-2:0], m_sh2[c]};
                if (m_fill[c] < DEB) m_fill[c]++;
                nd[c] = (m_fill[c] == DEB && m_win[c] == {DEB{m_sh2[c]}} && m_sh2[c] != m_d[c])
                        ? m_sh2[c] : m_d[c];
            end
`ifdef DOOR_INPUT_FAULT_EN
            nf = m_flt | (m_d[2] & m_d[3]);
`else
            nf = 1'b0;
`endif
            m_kup   = m_d[0] && !m_dprev[0] && !m_d[1] && !nf;
            m_kdn   = m_d[1] && !m_dprev[1] && !m_d[0] && !nf;
            m_dprev = m_d;
            m_d     = nd;
            m_flt   = nf;
            m_sh2   = m_sh1;
            m_sh1   = raw;
        end
    endtask

    // One clock: drive, advance model at the edge, compare just after it
    task automatic cyc(input logic r, input logic [3:0] raw);
        rst = r;
        {sense_down_raw, sense_up_raw, key_down_raw, key_up_raw} = raw;
        @(posedge clk2m);
        model_edge(r, raw);
        #1;
        check_eq("key_up",     key_up,     m_kup);
        check_eq("key_down",   key_down,   m_kdn);
        check_eq("sense_up",   sense_up,   m_d[2]);
        check_eq("sense_down", sense_down, m_d[3]);
        check_eq("fault",      fault,      m_flt);
        check_eq("one_hot",    key_up & key_down, 1'b0);
        n_kup += int'(key_up);
        n_kdn += int'(key_down);
    endtask

    task automatic hold(input logic [3:0] raw, input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, raw);
    endtask

    initial begin
        logic [3:0] rv;
        int         len;

        // Reset with all raws high, then key_up and sense_up kept high
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 4'hF);
            check_eq("rst_outs", key_up | key_down | sense_up | sense_down | fault, 1'b0);
        end
        for (int e = 1; e <= 9; e++) begin
            cyc(1'b0, 4'b0101);
            check_eq("rel_sense_up", sense_up, (e >= 6));
            check_eq("rel_key_up",   key_up,   (e == 7));
        end

        // Single key press: one pulse, 7 edges after the change, none on release
        cyc(1'b1, 4'h0);
        hold(4'h0, 8);
        n_kup = 0; n_kdn = 0;
        for (int e = 1; e <= 10; e++) begin
            cyc(1'b0, 4'b0001);
            check_eq("press_pulse", key_up, (e == 7));
        end
        hold(4'h0, 10);
        check_eq("press_cnt_up", (n_kup == 1), 1'b1);
        check_eq("press_cnt_dn", (n_kdn == 0), 1'b1);

        // Bouncing lower switch never accepted
        for (int e = 0; e < 20; e++) begin
            cyc(1'b0, ((e / 2) % 2 == 0) ? 4'b1000 : 4'b0000);
            check_eq("bounce_sd", sense_down, 1'b0);
        end
        for (int e = 0; e < 8; e++) begin
            cyc(1'b0, 4'h0);
            check_eq("bounce_sd", sense_down, 1'b0);
        end

        // Both keys together, then close pressed while open held
        n_kup = 0; n_kdn = 0;
        hold(4'b0011, 10);
        hold(4'h0, 8);
        check_eq("both_cnt", (n_kup + n_kdn == 0), 1'b1);
        hold(4'b0001, 8);
        hold(4'b0011, 10);
        hold(4'h0, 8);
        check_eq("veto_cnt_up", (n_kup == 1), 1'b1);
        check_eq("veto_cnt_dn", (n_kdn == 0), 1'b1);

        // Reset while the sense_up count is at 2 discards it
        hold(4'b0100, 4);
        cyc(1'b1, 4'b0100);
        for (int e = 1; e <= 8; e++) begin
            cyc(1'b0, 4'b0100);
            check_eq("mid_rst_su", sense_up, (e >= 6));
        end

        // Random held levels with bounces and occasional resets
        cyc(1'b1, 4'h0);
        for (int seg = 0; seg < 250; seg++) begin
            rv  = 4'($urandom_range(0, 15));
            len = $urandom_range(1, 12);
            if ($urandom_range(0, 29) == 0) cyc(1'b1, rv);
            hold(rv, len);
        end

        // Implausible end switches
        cyc(1'b1, 4'h0);
        n_kup = 0; n_kdn = 0;
        for (int e = 1; e <= 10; e++) begin
            cyc(1'b0, 4'b1100);
`ifdef DOOR_INPUT_FAULT_EN
            check_eq("fault_set", fault, (e >= 7));
`else
            check_eq("fault_set", fault, 1'b0);
`endif
        end
        hold(4'b1101, 8);
        hold(4'b1100, 8);
        hold(4'b1110, 8);
        hold(4'b1100, 8);
        check_eq("fault_sense", sense_up & sense_down, 1'b1);
`ifdef DOOR_INPUT_FAULT_EN
        check_eq("fault_blocks", (n_kup + n_kdn == 0), 1'b1);
`else
        check_eq("no_fault_pulses", (n_kup == 1 && n_kdn == 1), 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/door_input_cond.md
DOOR_INPUT_COND -- requirements
Module: door_input_cond

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 2000, the number of consecutive stable cycles (1 ms at 2 MHz) required to accept a new input level; legal range 2..65535.
REQ-002 SHALL have port clk2m, input, 1, the single system clock (2 MHz); all flops on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset, synchronous and active-high.
REQ-004 SHALL have port key_up_raw, input, 1, the asynchronous bouncing "open" push-button.
REQ-005 SHALL have port key_down_raw, input, 1, the asynchronous bouncing "close" push-button.
REQ-006 SHALL have port sense_up_raw, input, 1, the asynchronous bouncing upper end-position switch.
REQ-007 SHALL have port sense_down_raw, input, 1, the asynchronous bouncing lower end-position switch.
REQ-008 SHALL have port key_up, output, 1, a one-cycle conditioned open request to the door FSM.
REQ-009 SHALL have port key_down, output, 1, a one-cycle conditioned close request to the door FSM.
REQ-010 SHALL have port sense_up, output, 1, the debounced upper end-position level.
REQ-011 SHALL have port sense_down, output, 1, the debounced lower end-position level.
REQ-012 SHALL have port fault, output, 1, the sticky sensor-plausibility fault (see Configuration).

Function
REQ-013 SHALL pass each raw input through a 2-flop synchronizer, giving a synchronized sample s per channel.
REQ-014 SHALL keep, per channel, a debounced state d and a counter cnt of width $clog2(DEB_CYCLES).
REQ-015 SHALL handle each channel per cycle as follows:
- s==d: cnt<=0.
- s!=d and cnt==DEB_CYCLES-1: d<=s and cnt<=0.
- otherwise: cnt<=cnt+1.
REQ-016 SHALL, for a raw level held stable from before rising edge N, update d at edge N+1+DEB_CYCLES (2 sync edges plus DEB_CYCLES count edges).
REQ-017 SHALL leave d unchanged for a glitch or bounce shorter than DEB_CYCLES synchronized cycles, because cnt returns to 0.
REQ-018 SHALL drive sense_up and sense_down directly from the registered d of their channels.
REQ-019 SHALL assert key_up for exactly one cycle, the cycle after d_key_up rises 0->1, only if d_key_down is 0 in that cycle; key_down is symmetric.
REQ-020 SHALL suppress both pulses when d_key_up and d_key_down rise in the same cycle.
REQ-021 SHALL generate no pulse on a falling edge, and no further pulse while a key is held.
REQ-022 SHALL never assert key_up and key_down in the same cycle.
REQ-023 SHALL register all outputs, with no combinational path from any raw input to any output.

Reset
REQ-024 SHALL, while rst=1 at a clock edge, clear all synchronizer flops, d, cnt, edge-history flops and fault to 0.
REQ-025 SHALL hold key_up, key_down, sense_up, sense_down and fault at 0 during reset and on the first cycle after it.
REQ-026 SHALL discard any partial debounce count on reset mid-operation; after release, a raw level that is already high needs the full DEB_CYCLES+2 edges to appear.
REQ-027 SHALL treat a key already debounced high at reset release as a 0->1 edge and pulse once when d rises.

Configuration
REQ-028 SHALL, with macro DOOR_INPUT_FAULT_EN defined, set fault to 1 on the edge after d_sense_up and d_sense_down are both 1, and hold it until rst.
REQ-029 SHALL, while fault=1, force key_up and key_down to 0; sense_up and sense_down remain unaffected.
REQ-030 SHALL, without DOOR_INPUT_FAULT_EN, tie fault to constant 0, leave pulse generation unaffected, and contain no fault flop.

Verification (DEB_CYCLES=4, 500 ns clock)
REQ-031 SHALL cover: rst=1 for 3 cycles with all raws at 1 -> all outputs 0; after release, sense_up=1 at edge 6 and key_up one-cycle pulse at edge 7.
REQ-032 SHALL cover: key_up_raw 0->1 held 10 cycles -> exactly one key_up pulse, 7 edges after the change; key_down stays 0.
REQ-033 SHALL cover: sense_down_raw toggling every 2 cycles for 20 cycles, then 0 -> sense_down never rises.
REQ-034 SHALL cover: key_up_raw and key_down_raw rising on the same edge -> no pulse on either; key_down_raw rising while key_up held debounced -> no key_down pulse.
REQ-035 SHALL cover: rst pulsed for 1 cycle when the sense_up count is at 2 -> sense_up stays 0 and rises 6 edges after release.
REQ-036 SHALL cover, with DOOR_INPUT_FAULT_EN: sense_up_raw=sense_down_raw=1 -> fault=1 one edge after both debounced and held, subsequent key presses give no pulses; without the macro -> fault=0 and pulses occur.
